// File: rtl/remote_cmd_sched.sv
// Round-robin scheduler for two requesters sharing one RemoteComm link.
// One command in flight; resends on NAK or response timeout.
module remote_cmd_sched #(
  parameter int unsigned TIMEOUT_CYC = 10000000,
  parameter int unsigned MAX_RETRY   = 2,
  parameter logic [7:0]  POS_ACK     = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [7:0]  cmd0,
  input  logic [15:0] data0,
  input  logic [7:0]  cmd1,
  input  logic [15:0] data1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic [1:0]  status,
  output logic        busy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        send_cmd,
  input  logic        cmd_sent,
  input  logic        resp_rdy,
  input  logic [7:0]  resp,
  output logic        clr_resp_rdy
);

  localparam int TW =
    (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RW =
    (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] T_LAST =
    TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] R_MAX = RW'(MAX_RETRY);

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_NAK = 2'b01;
  localparam logic [1:0] ST_TMO = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_SENT,
    WAIT_RESP,
    FINISH
  } state_e;

  state_e        state_q, state_d;
  logic          win_q, win_d;
  logic          rr_q, rr_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [15:0]   data_q, data_d;
  logic [1:0]    status_q, status_d;
  logic          pick;

  // Lone requester wins outright; on contention rr decides.
  assign pick = req[1] & (~req[0] | rr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      win_q    <= 1'b0;
      rr_q     <= 1'b0;
      retry_q  <= '0;
      timer_q  <= '0;
      cmd_q    <= 8'h00;
      data_q   <= 16'h0000;
      status_q <= ST_OK;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      rr_q     <= rr_d;
      retry_q  <= retry_d;
      timer_q  <= timer_d;
      cmd_q    <= cmd_d;
      data_q   <= data_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    rr_d         = rr_q;
    retry_d      = retry_q;
    timer_d      = timer_q;
    cmd_d        = cmd_q;
    data_d       = data_q;
    status_d     = status_q;
    gnt          = 2'b00;
    done         = 2'b00;
    send_cmd     = 1'b0;
    clr_resp_rdy = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          win_d   = pick;
          rr_d    = ~pick;
          cmd_d   = pick ? cmd1 : cmd0;
          data_d  = pick ? data1 : data0;
          retry_d = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        send_cmd     = 1'b1;
        clr_resp_rdy = 1'b1;
        if (retry_q == '0) begin
          gnt = win_q ? 2'b10 : 2'b01;
        end
        state_d = WAIT_SENT;
      end
      WAIT_SENT: begin
        if (cmd_sent) begin
          timer_d = '0;
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        timer_d = timer_q + TW'(1);
        if (resp_rdy) begin
          clr_resp_rdy = 1'b1;
          timer_d      = '0;
          if (resp == POS_ACK) begin
            status_d = ST_OK;
            state_d  = FINISH;
          end else if (retry_q < R_MAX) begin
            retry_d = retry_q + RW'(1);
            state_d = SEND;
          end else begin
            status_d = ST_NAK;
            state_d  = FINISH;
          end
        end else if (timer_q == T_LAST) begin
          timer_d = '0;
          if (retry_q < R_MAX) begin
            retry_d = retry_q + RW'(1);
            state_d = SEND;
          end else begin
            status_d = ST_TMO;
            state_d  = FINISH;
          end
        end
      end
      FINISH: begin
        done    = win_q ? 2'b10 : 2'b01;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign cmd    = cmd_q;
  assign data   = data_q;
  assign status = status_q;

endmodule

// File: tb/tb_remote_cmd_sched.sv
// Randomized bench for remote_cmd_sched with a procedural
// transaction model and an emulated RemoteComm responder.
module tb_remote_cmd_sched;

  localparam int TO = 1000;
  localparam int MR = 2;
  localparam logic [7:0] ACK = 8'hA5;
  localparam int P_ACK  = 0;
  localparam int P_NAK  = 1;
  localparam int P_NONE = 2;
  localparam int P_EXP  = 3;
  localparam int P_RNAK = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [7:0]  cmd0, cmd1;
  logic [15:0] data0, data1;
  logic [1:0]  gnt, done, status;
  logic        busy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        send_cmd, cmd_sent, resp_rdy;
  logic [7:0]  resp;
  logic        clr_resp_rdy;

  remote_cmd_sched #(
    .TIMEOUT_CYC(TO),
    .MAX_RETRY(MR),
    .POS_ACK(ACK)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .cmd0(cmd0),
    .data0(data0),
    .cmd1(cmd1),
    .data1(data1),
    .gnt(gnt),
    .done(done),
    .status(status),
    .busy(busy),
    .cmd(cmd),
    .data(data),
    .send_cmd(send_cmd),
    .cmd_sent(cmd_sent),
    .resp_rdy(resp_rdy),
    .resp(resp),
    .clr_resp_rdy(clr_resp_rdy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0h required=%0h t=%0t",
                 nm, act, req_v, $time);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=no_event required=event t=%0t",
             nm, $time);
  endtask

  // ---------------- reference model ----------------
  logic [1:0]  e_gnt, e_done, e_status;
  logic        e_busy, e_send, e_clr;
  logic [7:0]  e_cmd;
  logic [15:0] e_data;
  int          m_rr;
  logic [7:0]  m_cmd;
  logic [15:0] m_dat;
  logic [1:0]  m_st;

  task automatic exp_base(input logic b);
    e_busy = b;
    e_gnt = 2'b00;
    e_done = 2'b00;
    e_send = 1'b0;
    e_clr = 1'b0;
    e_cmd = m_cmd;
    e_data = m_dat;
    e_status = m_st;
  endtask

  task automatic m_reset();
    m_rr = 0;
    m_cmd = 8'h00;
    m_dat = 16'h0000;
    m_st = 2'b00;
    exp_base(1'b0);
  endtask

  task automatic step(output bit ab);
    @(negedge clk);
    ab = !rst_n;
    if (ab) m_reset();
    else exp_base(1'b1);
  endtask

  task automatic run_txn(input int w, output bit ab);
    int tries;
    bit fin, again;
    logic [1:0] res;
    tries = 0;
    res = 2'b00;
    forever begin
      step(ab);
      if (ab) return;
      e_send = 1'b1;
      e_clr = 1'b1;
      if (tries == 0) e_gnt = (w == 1) ? 2'b10 : 2'b01;
      forever begin
        step(ab);
        if (ab) return;
        if (cmd_sent) break;
      end
      fin = 0;
      again = 0;
      for (int t = 0; !fin && !again; t++) begin
        step(ab);
        if (ab) return;
        if (resp_rdy) begin
          e_clr = 1'b1;
          if (resp == ACK) begin
            res = 2'b00; fin = 1;
          end else if (tries < MR) again = 1;
          else begin
            res = 2'b01; fin = 1;
          end
        end else if (t == TO - 1) begin
          if (tries < MR) again = 1;
          else begin
            res = 2'b10; fin = 1;
          end
        end
      end
      if (fin) break;
      tries++;
    end
    step(ab);
    if (ab) return;
    m_st = res;
    e_status = res;
    e_done = (w == 1) ? 2'b10 : 2'b01;
  endtask

  initial begin : ref_model
    int w;
    bit ab;
    m_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_reset();
        continue;
      end
      exp_base(1'b0);
      if (req != 2'b00) begin
        w = (req == 2'b11) ? m_rr : (req[1] ? 1 : 0);
        m_rr = 1 - w;
        m_cmd = (w == 1) ? cmd1 : cmd0;
        m_dat = (w == 1) ? data1 : data0;
        run_txn(w, ab);
      end
    end
  end

  // ---------------- compare + monitor ----------------
  int cyc = 0, n_send = 0, n_gnt = 0, n_done = 0;
  int sent_cyc = 0, gap_last = 0, gap_prev = 0;

  always @(negedge clk) begin
    #1;
    cyc++;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("done", 32'(done), 32'(e_done));
    chk("status", 32'(status), 32'(e_status));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("cmd", 32'(cmd), 32'(e_cmd));
    chk("data", 32'(data), 32'(e_data));
    chk("send_cmd", 32'(send_cmd), 32'(e_send));
    chk("clr_resp_rdy", 32'(clr_resp_rdy), 32'(e_clr));
    if (cmd_sent) sent_cyc = cyc;
    if (send_cmd) begin
      n_send++;
      gap_prev = gap_last;
      gap_last = cyc - sent_cyc;
    end
    if (gnt != 2'b00) n_gnt++;
    if (done != 2'b00) n_done++;
  end

  // ---------------- requester driver ----------------
  int posted[2] = '{0, 0};
  int gcnt[2] = '{0, 0};
  bit scramble = 0;
  logic [7:0]  f_cmd0 = 8'h00, f_cmd1 = 8'h00;
  logic [15:0] f_dat0 = 16'h0, f_dat1 = 16'h0;

  initial begin : drv
    req = 2'b00;
    cmd0 = 8'h00; cmd1 = 8'h00;
    data0 = 16'h0; data1 = 16'h0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        if (gnt[i]) gcnt[i]++;
      @(posedge clk);
      #1;
      req[0] = posted[0] > gcnt[0];
      req[1] = posted[1] > gcnt[1];
      if (scramble) begin
        cmd0 = 8'($urandom);
        cmd1 = 8'($urandom);
        data0 = 16'($urandom);
        data1 = 16'($urandom);
      end else begin
        cmd0 = f_cmd0;
        cmd1 = f_cmd1;
        data0 = f_dat0;
        data1 = f_dat1;
      end
    end
  end

  // ---------------- RemoteComm responder ----------------
  int plan[$];

  function automatic int rnd_code();
    int r;
    r = $urandom_range(0, 99);
    if (r < 60) return P_ACK;
    if (r < 90) return P_RNAK;
    if (r < 96) return P_NONE;
    return P_EXP;
  endfunction

  initial begin : remote
    int code, d, r;
    logic [7:0] nb;
    cmd_sent = 1'b0;
    resp_rdy = 1'b0;
    resp = 8'h00;
    forever begin
      @(negedge clk);
      if (!send_cmd) continue;
      code = (plan.size() > 0) ? plan.pop_front() : rnd_code();
      d = $urandom_range(1, 4);
      repeat (d) begin @(posedge clk); #1; end
      cmd_sent = 1'b1;
      @(posedge clk); #1;
      cmd_sent = 1'b0;
      if (code == P_NONE) continue;
      r = (code == P_EXP) ? TO - 1 : $urandom_range(0, 12);
      repeat (r) begin @(posedge clk); #1; end
      nb = 8'($urandom);
      if (nb == ACK) nb = 8'h5A;
      resp_rdy = 1'b1;
      resp = (code == P_ACK || code == P_EXP) ? ACK :
             (code == P_NAK) ? 8'hEE : nb;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (clr_resp_rdy) break;
      end
      @(posedge clk); #1;
      resp_rdy = 1'b0;
    end
  end

  // ---------------- directed + random sequence ----------------
  logic [1:0]  d_done, d_status;
  logic [7:0]  d_cmd;
  logic [15:0] d_data;

  task automatic wait_done(input int lim);
    for (int k = 0; k < lim; k++) begin
      @(negedge clk); #2;
      if (done != 2'b00) begin
        d_done = done;
        d_status = status;
        d_cmd = cmd;
        d_data = data;
        return;
      end
    end
    tmo("wait_done");
    d_done = 2'b00;
    d_status = 2'b11;
    d_cmd = 8'h00;
    d_data = 16'h0;
  endtask

  task automatic wait_req(input int i);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); #2;
      if (req[i]) return;
    end
    tmo("wait_req");
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    repeat (95000) @(posedge clk);
    tmo("watchdog");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : main
    int s, g, nd, tgt;
    logic [1:0] p;
    bit seen;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // single requester, immediate ACK
    f_cmd0 = 8'h05;
    f_dat0 = 16'h0020;
    plan.push_back(P_ACK);
    s = n_send; g = n_gnt;
    posted[0]++;
    wait_req(0);
    @(negedge clk); #2;
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_send", 32'(send_cmd), 32'h1);
    wait_done(3000);
    chk("t1_done", 32'(d_done), 32'h1);
    chk("t1_status", 32'(d_status), 32'h0);
    chk("t1_cmd", 32'(d_cmd), 32'h05);
    chk("t1_data", 32'(d_data), 32'h0020);
    chk("t1_sends", 32'(n_send - s), 32'd1);
    chk("t1_gnts", 32'(n_gnt - g), 32'd1);

    // contention from reset, then rr hand-over
    pulse_reset();
    f_cmd1 = 8'h0C;
    f_dat1 = 16'h1234;
    plan.push_back(P_ACK); plan.push_back(P_ACK);
    posted[0]++; posted[1]++;
    wait_done(3000);
    chk("t2_first", 32'(d_done), 32'h1);
    wait_done(3000);
    chk("t2_second", 32'(d_done), 32'h2);
    chk("t2_cmd", 32'(d_cmd), 32'h0C);
    plan.push_back(P_ACK);
    posted[0]++;
    wait_done(3000);
    chk("t2_solo", 32'(d_done), 32'h1);
    plan.push_back(P_ACK); plan.push_back(P_ACK);
    posted[0]++; posted[1]++;
    wait_done(3000);
    chk("t2_rr_first", 32'(d_done), 32'h2);
    wait_done(3000);
    chk("t2_rr_second", 32'(d_done), 32'h1);

    // two NAKs then ACK
    f_cmd0 = 8'h21;
    plan.push_back(P_NAK); plan.push_back(P_NAK);
    plan.push_back(P_ACK);
    s = n_send; g = n_gnt;
    posted[0]++;
    wait_done(3000);
    chk("t3_done", 32'(d_done), 32'h1);
    chk("t3_status", 32'(d_status), 32'h0);
    chk("t3_sends", 32'(n_send - s), 32'd3);
    chk("t3_gnts", 32'(n_gnt - g), 32'd1);

    // silent remote: three timeouts
    plan.push_back(P_NONE); plan.push_back(P_NONE);
    plan.push_back(P_NONE);
    s = n_send;
    posted[1]++;
    wait_done(4000);
    chk("t4_done", 32'(d_done), 32'h2);
    chk("t4_status", 32'(d_status), 32'h2);
    chk("t4_sends", 32'(n_send - s), 32'd3);
    chk("t4_gap2", 32'(gap_prev), 32'd1001);
    chk("t4_gap3", 32'(gap_last), 32'd1001);

    // ACK lands on the expiry cycle
    plan.push_back(P_EXP);
    s = n_send;
    posted[0]++;
    wait_done(2000);
    chk("t5_status", 32'(d_status), 32'h0);
    chk("t5_sends", 32'(n_send - s), 32'd1);

    // persistent NAK
    plan.push_back(P_RNAK); plan.push_back(P_RNAK);
    plan.push_back(P_RNAK);
    s = n_send;
    posted[1]++;
    wait_done(3000);
    chk("t6_done", 32'(d_done), 32'h2);
    chk("t6_status", 32'(d_status), 32'h1);
    chk("t6_sends", 32'(n_send - s), 32'd3);

    // async reset while waiting for a response
    plan.push_back(P_NONE);
    posted[0]++;
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = cmd_sent;
    end
    if (!seen) tmo("t7_cmd_sent");
    repeat (40) @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t7_busy", 32'(busy), 32'd0);
    chk("t7_status", 32'(status), 32'd0);
    chk("t7_cmd", 32'(cmd), 32'd0);
    chk("t7_data", 32'(data), 32'd0);
    nd = n_done;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    chk("t7_no_done", 32'(n_done), 32'(nd));
    f_cmd1 = 8'h33;
    f_dat1 = 16'hBEEF;
    plan.push_back(P_ACK);
    posted[1]++;
    wait_done(3000);
    chk("t7_after", 32'(d_done), 32'h2);
    chk("t7_after_st", 32'(d_status), 32'h0);
    chk("t7_after_cmd", 32'(d_cmd), 32'h33);
    chk("t7_after_data", 32'(d_data), 32'hBEEF);

    // randomized traffic
    scramble = 1;
    for (int it = 0; it < 40; it++) begin
      p = 2'($urandom_range(1, 3));
      tgt = n_done + int'(p[0]) + int'(p[1]);
      posted[0] += int'(p[0]);
      posted[1] += int'(p[1]);
      if (p != 2'b11 && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 30)) @(posedge clk);
        #1;
        if (p[0]) posted[1]++;
        else posted[0]++;
        tgt++;
      end
      seen = 0;
      for (int k = 0; k < 9000 && !seen; k++) begin
        @(negedge clk); #2;
        seen = (n_done >= tgt);
      end
      if (!seen) tmo("rand_done");
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
